// File: rtl/card_frame_rx.sv
// card_frame_rx: serial card-reader frame receiver; optional parity checking enabled by CARD_RX_PARITY_EN.
module card_frame_rx #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       bitIn,
  input  logic       bitValid,
  output logic [4:0] smartCode,
  output logic       lab,
  output logic [1:0] mode,
  output logic       frameValid,
  output logic       parityErr,
  output logic       framingErr,
  output logic       timeoutErr,
  output logic [7:0] errCount
);
`ifdef CARD_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t state, nxt_state;
  logic [2:0] idx, nxt_idx;
  logic [7:0] gap, nxt_gap, data, nxt_data;
  logic fv_n, fe_n, te_n, err_n;
`ifdef CARD_RX_PARITY_EN
  logic bad, nxt_bad, pe_n;
  assign err_n = pe_n | fe_n | te_n;
`else
  assign err_n = fe_n | te_n;
  assign parityErr = 1'b0;
`endif
  always_comb begin
    nxt_state = state;
    nxt_idx = idx;
    nxt_gap = gap;
    nxt_data = data;
    fv_n = 1'b0;
    fe_n = 1'b0;
    te_n = 1'b0;
`ifdef CARD_RX_PARITY_EN
    nxt_bad = bad;
    pe_n = 1'b0;
`endif
    if (state != IDLE && !bitValid) begin
      te_n = (gap == TIMEOUT - 8'd1);
      nxt_gap = te_n ? 8'd0 : gap + 8'd1;
      nxt_state = te_n ? IDLE : state;
    end
    if (bitValid) begin
      nxt_gap = 8'd0;
      case (state)
        IDLE: begin
          nxt_state = bitIn ? IDLE : DATA;
          nxt_idx = 3'd0;
        end
        DATA: begin
          nxt_data = {bitIn, data[7:1]};
          nxt_idx = idx + 3'd1;
`ifdef CARD_RX_PARITY_EN
          nxt_state = (idx == 3'd7) ? PARITY : DATA;
`else
          nxt_state = (idx == 3'd7) ? STOP : DATA;
`endif
        end
`ifdef CARD_RX_PARITY_EN
        PARITY: begin
          nxt_bad = ^{data, bitIn};
          nxt_state = STOP;
        end
        STOP: begin
          fv_n = bitIn & ~bad;
          pe_n = bitIn & bad;
          fe_n = ~bitIn;
          nxt_state = IDLE;
        end
`else
        STOP: begin
          fv_n = bitIn;
          fe_n = ~bitIn;
          nxt_state = IDLE;
        end
`endif
        default: nxt_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx <= 3'd0;
      gap <= 8'd0;
      data <= 8'd0;
      smartCode <= 5'd0;
      lab <= 1'b0;
      mode <= 2'b10;
      frameValid <= 1'b0;
      framingErr <= 1'b0;
      timeoutErr <= 1'b0;
      errCount <= 8'd0;
`ifdef CARD_RX_PARITY_EN
      bad <= 1'b0;
      parityErr <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      idx <= nxt_idx;
      gap <= nxt_gap;
      data <= nxt_data;
      frameValid <= fv_n;
      framingErr <= fe_n;
      timeoutErr <= te_n;
      mode <= fv_n ? data[7:6] : 2'b10;
      if (fv_n) {lab, smartCode} <= data[5:0];
      if (err_n && errCount != 8'hff) errCount <= errCount + 8'd1;
`ifdef CARD_RX_PARITY_EN
      bad <= nxt_bad;
      parityErr <= pe_n;
`endif
    end
  end
endmodule
